// File: rtl/id_pkg.sv
// id_pkg: opcode/func constants, ALU encodings and decoded-instruction struct for id_issue
package id_pkg;
  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_SLTIU    = 6'b001011;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_PREF     = 6'b110011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SYNC  = 6'b001111;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MOVZ  = 6'b001010;
  localparam logic [5:0] FN_MOVN  = 6'b001011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN2_CLZ  = 6'b100000;
  localparam logic [5:0] FN2_CLO  = 6'b100001;
  localparam logic [5:0] FN2_MUL  = 6'b000010;
  typedef enum logic [7:0] {
    ALU_NOP   = 8'h00, ALU_OR    = 8'h25, ALU_AND   = 8'h24, ALU_XOR   = 8'h26,
    ALU_NOR   = 8'h27, ALU_SLL   = 8'h7c, ALU_SRL   = 8'h02, ALU_SRA   = 8'h03,
    ALU_MOVZ  = 8'h0a, ALU_MOVN  = 8'h0b, ALU_MFHI  = 8'h10, ALU_MTHI  = 8'h11,
    ALU_MFLO  = 8'h12, ALU_MTLO  = 8'h13, ALU_SLT   = 8'h2a, ALU_SLTU  = 8'h2b,
    ALU_ADD   = 8'h20, ALU_ADDU  = 8'h21, ALU_SUB   = 8'h22, ALU_SUBU  = 8'h23,
    ALU_MULT  = 8'h18, ALU_MULTU = 8'h19, ALU_ADDI  = 8'h55, ALU_ADDIU = 8'h56,
    ALU_CLZ   = 8'hb0, ALU_CLO   = 8'hb1, ALU_MUL   = 8'ha9
  } aluop_e;
  typedef enum logic [2:0] {
    SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_MOVE = 3'd3, SEL_ARITH = 3'd4, SEL_MUL = 3'd5
  } alusel_e;
  typedef struct packed {
    aluop_e      aluop;
    alusel_e     alusel;
    logic [4:0]  wd;
    logic        wreg;
    logic        read1;
    logic        read2;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;
endpackage

// File: rtl/id_decode.sv
// id_decode: combinational MIPS decoder, inst_i -> dec_o (aluop, alusel, wd, wreg, read enables, imm, illegal)
module id_decode import id_pkg::*; (
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, sa;
  logic [15:0] imm16;
  dec_t d;
  assign {op, rs, rt, rd, sa, fn} = inst_i;
  assign imm16 = inst_i[15:0];
  always_comb begin
    d = '0;
    case (op)
      OP_SPECIAL: begin
        d.wd = rd; d.wreg = 1'b1; d.read1 = 1'b1; d.read2 = 1'b1;
        case (fn)
          FN_OR:    begin d.aluop = ALU_OR;   d.alusel = SEL_LOGIC; end
          FN_AND:   begin d.aluop = ALU_AND;  d.alusel = SEL_LOGIC; end
          FN_XOR:   begin d.aluop = ALU_XOR;  d.alusel = SEL_LOGIC; end
          FN_NOR:   begin d.aluop = ALU_NOR;  d.alusel = SEL_LOGIC; end
          FN_SLLV:  begin d.aluop = ALU_SLL;  d.alusel = SEL_SHIFT; end
          FN_SRLV:  begin d.aluop = ALU_SRL;  d.alusel = SEL_SHIFT; end
          FN_SRAV:  begin d.aluop = ALU_SRA;  d.alusel = SEL_SHIFT; end
          FN_SLL:   begin d.aluop = ALU_SLL;  d.alusel = SEL_SHIFT; d.read1 = 1'b0; d.imm = {27'd0, sa}; d.illegal = rs != 5'd0; end
          FN_SRL:   begin d.aluop = ALU_SRL;  d.alusel = SEL_SHIFT; d.read1 = 1'b0; d.imm = {27'd0, sa}; d.illegal = rs != 5'd0; end
          FN_SRA:   begin d.aluop = ALU_SRA;  d.alusel = SEL_SHIFT; d.read1 = 1'b0; d.imm = {27'd0, sa}; d.illegal = rs != 5'd0; end
          FN_MFHI:  begin d.aluop = ALU_MFHI; d.alusel = SEL_MOVE;  d.read1 = 1'b0; d.read2 = 1'b0; end
          FN_MFLO:  begin d.aluop = ALU_MFLO; d.alusel = SEL_MOVE;  d.read1 = 1'b0; d.read2 = 1'b0; end
          FN_MTHI:  begin d.aluop = ALU_MTHI; d.read2 = 1'b0; d.wreg = 1'b0; end
          FN_MTLO:  begin d.aluop = ALU_MTLO; d.read2 = 1'b0; d.wreg = 1'b0; end
          FN_MOVN:  begin d.aluop = ALU_MOVN; d.alusel = SEL_MOVE; end
          FN_MOVZ:  begin d.aluop = ALU_MOVZ; d.alusel = SEL_MOVE; end
          FN_SLT:   begin d.aluop = ALU_SLT;  d.alusel = SEL_ARITH; end
          FN_SLTU:  begin d.aluop = ALU_SLTU; d.alusel = SEL_ARITH; end
          FN_ADD:   begin d.aluop = ALU_ADD;  d.alusel = SEL_ARITH; end
          FN_ADDU:  begin d.aluop = ALU_ADDU; d.alusel = SEL_ARITH; end
          FN_SUB:   begin d.aluop = ALU_SUB;  d.alusel = SEL_ARITH; end
          FN_SUBU:  begin d.aluop = ALU_SUBU; d.alusel = SEL_ARITH; end
          FN_MULT:  begin d.aluop = ALU_MULT;  d.wreg = 1'b0; end
          FN_MULTU: begin d.aluop = ALU_MULTU; d.wreg = 1'b0; end
          FN_SYNC:  begin d.wreg = 1'b0; d.read1 = 1'b0; d.read2 = 1'b0; end
          default:  d.illegal = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        d.wd = rd; d.wreg = 1'b1; d.read1 = 1'b1;
        case (fn)
          FN2_CLZ: begin d.aluop = ALU_CLZ; d.alusel = SEL_ARITH; end
          FN2_CLO: begin d.aluop = ALU_CLO; d.alusel = SEL_ARITH; end
          FN2_MUL: begin d.aluop = ALU_MUL; d.alusel = SEL_MUL; d.read2 = 1'b1; end
          default: d.illegal = 1'b1;
        endcase
      end
      OP_ORI:   begin d.aluop = ALU_OR;    d.alusel = SEL_LOGIC; d.imm = {16'd0, imm16}; end
      OP_ANDI:  begin d.aluop = ALU_AND;   d.alusel = SEL_LOGIC; d.imm = {16'd0, imm16}; end
      OP_XORI:  begin d.aluop = ALU_XOR;   d.alusel = SEL_LOGIC; d.imm = {16'd0, imm16}; end
      OP_LUI:   begin d.aluop = ALU_OR;    d.alusel = SEL_LOGIC; d.imm = {imm16, 16'd0}; end
      OP_SLTI:  begin d.aluop = ALU_SLT;   d.alusel = SEL_ARITH; d.imm = {{16{imm16[15]}}, imm16}; end
      OP_SLTIU: begin d.aluop = ALU_SLTU;  d.alusel = SEL_ARITH; d.imm = {{16{imm16[15]}}, imm16}; end
      OP_ADDI:  begin d.aluop = ALU_ADDI;  d.alusel = SEL_ARITH; d.imm = {{16{imm16[15]}}, imm16}; end
      OP_ADDIU: begin d.aluop = ALU_ADDIU; d.alusel = SEL_ARITH; d.imm = {{16{imm16[15]}}, imm16}; end
      OP_PREF:  ;
      default:  d.illegal = 1'b1;
    endcase
    if (op inside {OP_ORI, OP_ANDI, OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU, OP_ADDI, OP_ADDIU}) begin
      d.wd = rt; d.wreg = 1'b1; d.read1 = 1'b1;
    end
    if (d.illegal) begin
      d = '0;
      d.illegal = 1'b1;
    end
  end
  assign dec_o = d;
endmodule

// File: rtl/id_issue.sv
// id_issue: MIPS decode/issue stage with operand forwarding (ID_FWD_EN), load-use interlock, ID/EX register, stall counter
module id_issue import id_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int FWD_PORTS = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          if_valid_i,
  output logic                          if_ready_o,
  input  logic [31:0]                   pc_i,
  input  logic [31:0]                   inst_i,
  output logic [ADDR_W-1:0]             reg1_addr_o,
  output logic [ADDR_W-1:0]             reg2_addr_o,
  input  logic [DATA_W-1:0]             reg1_data_i,
  input  logic [DATA_W-1:0]             reg2_data_i,
  input  logic [FWD_PORTS-1:0]          fwd_wreg_i,
  input  logic [FWD_PORTS*ADDR_W-1:0]   fwd_wd_i,
  input  logic [FWD_PORTS*DATA_W-1:0]   fwd_wdata_i,
  input  logic [FWD_PORTS-1:0]          fwd_pend_i,
  input  logic                          flush_i,
  output logic                          ex_valid_o,
  input  logic                          ex_ready_i,
  output logic [31:0]                   pc_o,
  output logic [ALUOP_W-1:0]            aluop_o,
  output logic [ALUSEL_W-1:0]           alusel_o,
  output logic [DATA_W-1:0]             reg1_o,
  output logic [DATA_W-1:0]             reg2_o,
  output logic [ADDR_W-1:0]             wd_o,
  output logic                          wreg_o,
  output logic                          illegal_o,
  output logic [15:0]                   stall_cnt_o
);
  typedef struct packed {
    logic [31:0]         pc;
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [DATA_W-1:0]   reg1;
    logic [DATA_W-1:0]   reg2;
    logic [ADDR_W-1:0]   wd;
    logic                wreg;
    logic                illegal;
  } ex_t;
  dec_t dec;
  ex_t ex_q, ex_d;
  logic ex_valid_q, ex_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] rdata, opnd;
  logic [1:0] rden, haz;
  logic hazard, advance, accept, wreg;
  id_decode u_dec (.inst_i(inst_i), .dec_o(dec));
  assign reg1_addr_o = ADDR_W'(inst_i[25:21]);
  assign reg2_addr_o = ADDR_W'(inst_i[20:16]);
  assign addr  = {reg2_addr_o, reg1_addr_o};
  assign rdata = {reg2_data_i, reg1_data_i};
  assign rden  = {dec.read2, dec.read1};
`ifndef ID_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{fwd_wdata_i, fwd_pend_i};
`endif
  // Ports are scanned oldest-first so the youngest (lowest index) match wins.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      opnd[i] = !rden[i] ? DATA_W'(dec.imm) : (addr[i] == '0) ? '0 : rdata[i];
      haz[i] = 1'b0;
      for (int k = FWD_PORTS - 1; k >= 0; k--)
        if (rden[i] && addr[i] != '0 && fwd_wreg_i[k] && fwd_wd_i[k*ADDR_W +: ADDR_W] == addr[i]) begin
`ifdef ID_FWD_EN
          opnd[i] = fwd_wdata_i[k*DATA_W +: DATA_W];
          haz[i] = fwd_pend_i[k];
`else
          haz[i] = 1'b1;
`endif
        end
    end
  end
  assign hazard     = |haz;
  assign advance    = !ex_valid_q || ex_ready_i;
  assign if_ready_o = advance && !hazard && !flush_i;
  assign accept     = if_valid_i && if_ready_o;
  assign wreg = (dec.aluop == ALU_MOVN) ? |opnd[1] : (dec.aluop == ALU_MOVZ) ? ~|opnd[1] : dec.wreg;
  always_comb begin
    ex_d = accept ? '{pc: pc_i, aluop: ALUOP_W'(dec.aluop), alusel: ALUSEL_W'(dec.alusel), reg1: opnd[0],
                      reg2: opnd[1], wd: ADDR_W'(dec.wd), wreg: wreg, illegal: dec.illegal} : ex_q;
    ex_valid_d = accept ? 1'b1 : (flush_i || advance) ? 1'b0 : ex_valid_q;
    stall_cnt_d = (if_valid_i && hazard && !flush_i && stall_cnt_q != 16'hffff) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
      ex_valid_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      ex_valid_q <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign ex_valid_o  = ex_valid_q;
  assign pc_o        = ex_q.pc;
  assign aluop_o     = ex_q.aluop;
  assign alusel_o    = ex_q.alusel;
  assign reg1_o      = ex_q.reg1;
  assign reg2_o      = ex_q.reg2;
  assign wd_o        = ex_q.wd;
  assign wreg_o      = ex_q.wreg;
  assign illegal_o   = ex_q.illegal;
  assign stall_cnt_o = stall_cnt_q;
endmodule

// File: doc/id_issue.md
# id_issue

Registered, parametrised decode/issue stage for the 5-stage MIPS core, sitting between the IF/ID register and EX. It decodes one instruction per cycle, resolves operands from the register file or from FWD_PORTS forwarding sources, interlocks on load-use hazards, and holds the decoded result in an ID/EX register with a valid/ready handshake, flush, and a stall counter.

## Interface
- DATA_W, 32, datapath and register width
- ADDR_W, 5, register address width
- FWD_PORTS, 2, number of forwarding sources; index 0 is youngest (EX), higher indices are older
- ALUOP_W, 8, aluop width
- ALUSEL_W, 3, alusel width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_valid_i  in  1  instruction on pc_i/inst_i is valid
- if_ready_o  out  1  stage accepts instruction this cycle
- pc_i  in  32  instruction address
- inst_i  in  32  instruction word
- reg1_addr_o, reg2_addr_o  out  ADDR_W  register file read addresses: rs, rt; combinational
- reg1_data_i, reg2_data_i  in  DATA_W  register file read data, same cycle
- fwd_wreg_i  in  FWD_PORTS  per-port write enable
- fwd_wd_i  in  FWD_PORTS*ADDR_W  per-port destination, packed, port k at [k*ADDR_W +: ADDR_W]
- fwd_wdata_i  in  FWD_PORTS*DATA_W  per-port result, packed
- fwd_pend_i  in  FWD_PORTS  per-port result not yet available, e.g. a load in EX
- flush_i  in  1  squash ID/EX contents and the current input
- ex_valid_o  out  1  ID/EX register holds an instruction
- ex_ready_i  in  1  EX consumes the instruction this cycle
- pc_o  out  32; aluop_o  out  ALUOP_W; alusel_o  out  ALUSEL_W
- reg1_o, reg2_o  out  DATA_W  resolved operands
- wd_o  out  ADDR_W; wreg_o  out  1  destination and write enable
- illegal_o  out  1  the issued instruction is undefined
- stall_cnt_o  out  16  saturating count of load-use stall cycles

## Operation
- Decode, combinational: SPECIAL OR/AND/XOR/NOR/SLLV/SRLV/SRAV/SLL/SRL/SRA/MFHI/MFLO/MTHI/MTLO/MOVN/MOVZ/SLT/SLTU/ADD/ADDU/SUB/SUBU/MULT/MULTU/SYNC; ORI/ANDI/XORI/LUI/SLTI/SLTIU/ADDI/ADDIU/PREF; SPECIAL2 CLZ/CLO/MUL.
- Destination: R-type writes rd; I-type writes rt.
- Immediates:
  - Zero-extended for ORI/ANDI/XORI.
  - {imm16,16'h0} for LUI.
  - Sign-extended for SLTI/SLTIU/ADDI/ADDIU.
  - sa zero-extended for SLL/SRL/SRA.
- Operand source: a read-disabled operand takes the immediate. A read-enabled operand takes the lowest-index port k with fwd_wreg_i[k] and fwd_wd_i[k]==addr; if no port matches, it takes the register file.
- Register 0 is never forwarded and always reads 0.
- SLL/SRL/SRA with rs!=0, and any undecoded opcode or func, are illegal. They issue as NOP with wreg_o=0 and illegal_o=1.
- MOVN/MOVZ: wreg_o is derived from the resolved (forwarded) rt value, ≠0 or ==0 respectively.
- Hazard: a read-enabled operand whose selected port has fwd_pend_i set.
- advance = !ex_valid_o || ex_ready_i.
- if_ready_o = advance && !hazard && !flush_i.
- On each clock edge, in priority order:
  1. rst: all outputs and registers 0.
  2. flush_i: ex_valid_o←0.
  3. advance && if_valid_i && !hazard: load the ID/EX register, ex_valid_o←1.
  4. advance otherwise: ex_valid_o←0 (bubble).
  5. Else hold.
- stall_cnt_o increments on each cycle where if_valid_i && hazard && !flush_i, and saturates at 0xFFFF.

## Timing
- Latency: an instruction accepted in cycle n is presented with ex_valid_o=1 in cycle n+1.
- While ex_valid_o && !ex_ready_i, every ID/EX output is stable.
- Operands are sampled at acceptance. Later changes on fwd_*/reg*_data_i do not affect a held instruction.
- Reset values: ex_valid_o, wreg_o, illegal_o, pc_o, aluop_o (NOP), alusel_o (NOP), reg1_o, reg2_o, wd_o, stall_cnt_o are all 0.
- reg*_addr_o follow inst_i combinationally, also during reset.
- Simultaneous flush_i and a valid input: the input is not accepted (if_ready_o=0).
- A hazard that clears in cycle m is accepted in cycle m, assuming advance.
- Reset mid-stall clears the counter and the register.

## Configuration
- ID_FWD_EN defined: forwarding as specified above.
- ID_FWD_EN undefined:
  - Operands always come from the register file.
  - Any read-enabled operand matching any port with fwd_wreg_i set is a hazard.
  - fwd_wdata_i is unused.

## Structure
- Package id_pkg holds:
  - Opcode and func constants.
  - ALUOP/ALUSEL encodings.
  - A decoded-instruction struct typedef {aluop, alusel, wd, wreg, read1, read2, imm, illegal}.
- Sub-module id_decode: a purely combinational decoder from inst_i to the struct.
- The top level holds forwarding resolution, hazard detection, the ID/EX register, and the counter.

## Test plan
- ORI $1,$0,0x1234 (0x34011234), no forwarding → next cycle: ex_valid_o=1, aluop OR, reg1_o=0, reg2_o=0x00001234, wd_o=1, wreg_o=1.
- ADD $3,$1,$2 with port0 {wd=1, 0x0000AAAA} and port1 {wd=1, 0x00005555}; regfile $2=7 → reg1_o=0x0000AAAA, reg2_o=7.
- Same ADD with port0 {wd=2, pend=1} for 3 cycles → if_ready_o=0, bubbles issued, stall_cnt_o=3. The instruction issues the cycle after pend drops.
- ex_ready_i=0 for 4 cycles with a held instruction → all outputs unchanged, if_ready_o=0.
- flush_i while ex_valid_o=1 and a valid input → ex_valid_o=0 next cycle, input not consumed.
- inst 0xFC000000 → illegal_o=1, wreg_o=0, aluop NOP. Build without ID_FWD_EN and repeat scenario 2 → stalls while ports match.
